// File: rtl/clk_enable_gen.sv
// rtl/clk_enable_gen.sv - multi-channel programmable tick / square-wave clock-enable generator
// Optional phase-alignment input `sync` is present only when CLKDIV_SYNC_EN is defined.
module clk_enable_gen #(
    parameter int CHANNELS  = 4,
    parameter int DIV_W     = 8,
    parameter int RESET_DIV = 1,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [DIV_W-1:0]    cfg_div,
    output logic [CHANNELS-1:0] cfg_pending,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] clk_out
`ifdef CLKDIV_SYNC_EN
    ,
    input  logic                sync
`endif
);

    for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
        logic [DIV_W-1:0] div_q;
        logic [DIV_W-1:0] cnt_q;
        logic [DIV_W-1:0] pend_div_q;
        logic             pend_q;
        logic             tick_q;
        logic             clk_q;
        logic             wr_hit;

        // Out-of-range channel numbers match no channel and are dropped.
        assign wr_hit = cfg_we && (32'(cfg_ch) == n);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                div_q      <= DIV_W'(RESET_DIV);
                cnt_q      <= '0;
                pend_div_q <= '0;
                pend_q     <= 1'b0;
                tick_q     <= 1'b0;
                clk_q      <= 1'b0;
            end else begin
`ifdef CLKDIV_SYNC_EN
                if (sync || (div_q == '0)) begin
`else
                if (div_q == '0) begin
`endif
                    cnt_q  <= '0;
                    tick_q <= 1'b0;
                    clk_q  <= 1'b0;
                    if (pend_q) begin
                        div_q  <= pend_div_q;
                        pend_q <= 1'b0;
                    end
                end else if (cnt_q == (div_q - DIV_W'(1))) begin
                    // Divisor changes only land here, so no period is ever cut short.
                    cnt_q  <= '0;
                    tick_q <= 1'b1;
                    if (pend_q) begin
                        div_q  <= pend_div_q;
                        pend_q <= 1'b0;
                        clk_q  <= (pend_div_q == '0) ? 1'b0 : ~clk_q;
                    end else begin
                        clk_q  <= ~clk_q;
                    end
                end else begin
                    cnt_q  <= cnt_q + DIV_W'(1);
                    tick_q <= 1'b0;
                end

                // A write on an apply edge stays pending for the next period.
                if (wr_hit) begin
                    pend_div_q <= cfg_div;
                    pend_q     <= 1'b1;
                end
            end
        end

        assign cfg_pending[n] = pend_q;
        assign tick[n]        = tick_q;
        assign clk_out[n]     = clk_q;
    end

endmodule

// File: tb/tb_clk_enable_gen.sv
// tb/tb_clk_enable_gen.sv - scoreboard bench for clk_enable_gen
module tb_clk_enable_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_ch = '0;
    logic [7:0] cfg_div = '0;
    logic       sync = 1'b0;
    logic [3:0] cfg_pending, tick, clk_out;

    logic       we5 = 1'b0;
    logic [2:0] ch5 = '0;
    logic [3:0] div5 = '0;
    logic [4:0] pend5, tick5, clk5;

    clk_enable_gen #(.CHANNELS(4), .DIV_W(8), .RESET_DIV(1)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
        .cfg_pending(cfg_pending), .tick(tick), .clk_out(clk_out)
`ifdef CLKDIV_SYNC_EN
        , .sync(sync)
`endif
    );

    clk_enable_gen #(.CHANNELS(5), .DIV_W(4), .RESET_DIV(2)) dut5 (
        .clk(clk), .rst(rst), .cfg_we(we5), .cfg_ch(ch5), .cfg_div(div5),
        .cfg_pending(pend5), .tick(tick5), .clk_out(clk5)
`ifdef CLKDIV_SYNC_EN
        , .sync(1'b0)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] tick;
        logic [3:0] clko;
        logic [3:0] pend;
    } exp_t;

    exp_t exp_q[$];
    int   m_div[4], m_cnt[4], m_pdiv[4];
    bit   m_pend[4], m_clk[4];
    int   checks, failures;
    int   cyc;
    int   last_t[4];
    int   iv[$];
    int   trk_ch;
    int   ap;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic void model_reset();
        for (int n = 0; n < 4; n++) begin
            m_div[n] = 1; m_cnt[n] = 0; m_pdiv[n] = 0; m_pend[n] = 0; m_clk[n] = 0;
            last_t[n] = -1;
        end
        exp_q.delete();
        iv.delete();
    endfunction

    // Expected outputs after the coming edge, given the inputs driven for it.
    function automatic exp_t model_step(bit we, int ch, int dv, bit sy);
        exp_t e;
        for (int n = 0; n < 4; n++) begin
            e.tick[n] = 1'b0;
            if (sy || m_div[n] == 0) begin
                m_cnt[n] = 0;
                m_clk[n] = 0;
                if (m_pend[n]) begin m_div[n] = m_pdiv[n]; m_pend[n] = 0; end
            end else if (m_cnt[n] + 1 == m_div[n]) begin
                m_cnt[n] = 0;
                e.tick[n] = 1'b1;
                m_clk[n] = ~m_clk[n];
                if (m_pend[n]) begin
                    m_div[n] = m_pdiv[n];
                    m_pend[n] = 0;
                    if (m_div[n] == 0) m_clk[n] = 0;
                end
            end else begin
                m_cnt[n]++;
            end
            if (we && ch == n) begin m_pdiv[n] = dv; m_pend[n] = 1; end
            e.clko[n] = m_clk[n];
            e.pend[n] = m_pend[n];
        end
        return e;
    endfunction

    task automatic step(input bit we = 0, input int ch = 0, input int dv = 0, input bit sy = 0);
        exp_t e;
        cfg_we  = we;
        cfg_ch  = 2'(ch);
        cfg_div = 8'(dv);
        sync    = sy;
        exp_q.push_back(model_step(we, ch, dv, sy));
        @(negedge clk);
        cyc++;
        e = exp_q.pop_front();
        check("tick", 32'(tick), 32'(e.tick));
        check("clk_out", 32'(clk_out), 32'(e.clko));
        check("cfg_pending", 32'(cfg_pending), 32'(e.pend));
        for (int n = 0; n < 4; n++) begin
            if (tick[n]) begin
                if (n == trk_ch && last_t[n] >= 0) iv.push_back(cyc - last_t[n]);
                last_t[n] = cyc;
            end
        end
        cfg_we = 1'b0;
        sync   = 1'b0;
    endtask

    task automatic idle(input int k);
        repeat (k) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; failures = 0; cyc = 0; trk_ch = 0;
        model_reset();
        @(negedge clk);
        check("rst_tick", 32'(tick), 0);
        check("rst_clk_out", 32'(clk_out), 0);
        check("rst_pending", 32'(cfg_pending), 0);
        check("rst_pend5", 32'(pend5), 0);
        rst = 1'b0;

        // Reset divisor 1: every channel ticks every edge, clk_out = clk/2.
        step();
        check("t1_tick_e1", 32'(tick), 32'hF);
        check("t1_clk_e1", 32'(clk_out), 32'hF);
        step();
        check("t1_clk_e2", 32'(clk_out), 0);
        idle(3);

        // ch2 -> 5
        trk_ch = 2;
        step(1, 2, 5);
        check("t2_pend_set", 32'(cfg_pending[2]), 1);
        step();
        check("t2_pend_clr", 32'(cfg_pending[2]), 0);
        iv.delete();
        idle(15);
        check("t2_count", iv.size(), 3);
        foreach (iv[i]) check("t2_period", iv[i], 5);

        // ch1 div 8, rewrite to 3 at cnt==2
        trk_ch = 1;
        step(1, 1, 8);
        step();
        iv.delete();
        idle(2);
        step(1, 1, 3);
        idle(12);
        check("t3_count", iv.size(), 3);
        if (iv.size() == 3) begin
            check("t3_old_period", iv[0], 8);
            check("t3_new_period_a", iv[1], 3);
            check("t3_new_period_b", iv[2], 3);
        end

        // ch0 disable, then re-enable with 4
        trk_ch = 0;
        step(1, 0, 0);
        step();
        check("t4_final_tick", 32'(tick[0]), 1);
        check("t4_clk_low", 32'(clk_out[0]), 0);
        idle(5);
        check("t4_clk_stays_low", 32'(clk_out[0]), 0);
        step(1, 0, 4);
        check("t4_pend_set", 32'(cfg_pending[0]), 1);
        step();
        check("t4_pend_clr", 32'(cfg_pending[0]), 0);
        ap = cyc;
        idle(5);
        check("t4_first_tick", last_t[0] - ap, 4);

        // ch3: last of two pending writes wins; out-of-range channel on dut5
        trk_ch = 3;
        step(1, 3, 7);
        step();
        iv.delete();
        we5 = 1'b1; ch5 = 3'd7; div5 = 4'd3;
        step(1, 3, 6);
        we5 = 1'b0;
        check("oor_pend5", 32'(pend5), 0);
        we5 = 1'b1; ch5 = 3'd4; div5 = 4'd3;
        step();
        we5 = 1'b0;
        check("valid_pend5", 32'(pend5), 32'h10);
        step(1, 3, 9);
        check("t5_pend", 32'(cfg_pending[3]), 1);
        idle(23);
        check("t5_count", iv.size(), 3);
        if (iv.size() == 3) begin
            check("t5_first", iv[0], 7);
            check("t5_last_wins_a", iv[1], 9);
            check("t5_last_wins_b", iv[2], 9);
        end

`ifdef CLKDIV_SYNC_EN
        step(1, 0, 3);
        step(1, 1, 6);
        idle(10 + int'($urandom_range(0, 7)));
        step(0, 0, 0, 1);
        ap = cyc;
        check("sync_clk_low", 32'(clk_out[1:0]), 0);
        idle(3);
        check("sync_ch0_tick", last_t[0] - ap, 3);
        idle(3);
        check("sync_ch1_tick", last_t[1] - ap, 6);
`endif

        // Asynchronous reset mid-period drops everything, including pending writes.
        step(1, 2, 9);
        check("pre_rst_pend", 32'(cfg_pending[2]), 1);
        #2 rst = 1'b1;
        #1;
        check("arst_tick", 32'(tick), 0);
        check("arst_clk_out", 32'(clk_out), 0);
        check("arst_pending", 32'(cfg_pending), 0);
        check("arst_pend5", 32'(pend5), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step();
        check("post_rst_tick", 32'(tick), 32'hF);
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
